// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment driver: captures a value on load, shows it in hex or decimal
// (sequential double-dabble). Optional blink gating is built when SEG7_BLINK_EN is defined.
module seg7_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int VALUE_W    = 24,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [VALUE_W-1:0]      value,
   input  logic                    load,
   input  logic                    mode_dec,
   input  logic                    blank_lz,
   input  logic                    blink,
   output logic [7*NUM_DIGITS-1:0] hex_out,
   output logic                    busy,
   output logic                    overflow
);

   localparam int BCD_RAW = (VALUE_W * 302 + 999) / 1000 + 1;
   localparam int BCD_D   = (BCD_RAW > NUM_DIGITS) ? BCD_RAW : NUM_DIGITS;
   localparam int CW      = $clog2(VALUE_W + 1);
   localparam int XW      = (VALUE_W > 4 * NUM_DIGITS) ? VALUE_W : 4 * NUM_DIGITS;

   typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

   state_t                    state, state_nxt;
   logic [VALUE_W-1:0]        val_r;
   logic                      dec_r, blz_r;
   logic [4*BCD_D-1:0]        bcd, adj, bcd_nxt;
   logic [CW-1:0]             cnt;
   logic [7*NUM_DIGITS-1:0]   disp, disp_nxt;
   logic                      ovf_r, ovf_nxt, hide, accept, last;
   logic [XW-1:0]             val_x;
   logic [3:0]                dig;
   logic                      lead, hovf, dovf;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // busy also gates acceptance so the cycle after SHOW cannot start a new decimal load
   assign accept = (state == IDLE) && load && !busy;
   assign last   = (cnt == CW'(VALUE_W - 1));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = mode_dec ? CONV : SHOW;
         CONV:    if (last) state_nxt = SHOW;
         SHOW:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // one shift-add-3 step: adjust every BCD digit >= 5, then shift in the next value MSB
   always_comb begin
      adj = bcd;
      for (int d = 0; d < BCD_D; d++)
         if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      bcd_nxt = (adj << 1) | {{(4*BCD_D-1){1'b0}}, val_r[VALUE_W-1]};
   end

   always_comb begin
      val_x    = XW'(val_r);
      hovf     = (val_x >> (4 * NUM_DIGITS)) != '0;
      dovf     = 1'b0;
      for (int k = NUM_DIGITS; k < BCD_D; k++)
         if (bcd[4*k +: 4] != 4'd0) dovf = 1'b1;
      ovf_nxt  = dec_r ? dovf : hovf;
      lead     = 1'b1;
      dig      = 4'd0;
      disp_nxt = '1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         dig = dec_r ? bcd[4*k +: 4] : val_x[4*k +: 4];
         if (dig != 4'd0) lead = 1'b0;
         if (ovf_nxt)                         disp_nxt[7*k +: 7] = 7'b0111111;
         else if (blz_r && lead && (k != 0))  disp_nxt[7*k +: 7] = 7'b1111111;
         else                                 disp_nxt[7*k +: 7] = seg7(dig);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         val_r <= '0;
         dec_r <= 1'b0;
         blz_r <= 1'b0;
         bcd   <= '0;
         cnt   <= '0;
         disp  <= '1;
         ovf_r <= 1'b0;
         busy  <= 1'b0;
      end else begin
         busy <= (state != IDLE) && dec_r;
         if (accept) begin
            val_r <= value;
            dec_r <= mode_dec;
            blz_r <= blank_lz;
            bcd   <= '0;
            cnt   <= '0;
         end
         if (state == CONV) begin
            val_r <= val_r << 1;
            bcd   <= bcd_nxt;
            cnt   <= cnt + CW'(1);
         end
         if (state == SHOW) begin
            disp  <= disp_nxt;
            ovf_r <= ovf_nxt;
         end
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);
   logic [BW-1:0] bcnt;
   logic          phase;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt  <= bcnt + BW'(1);
      end
   end

   assign hide = blink && phase;
`else
   logic unused_blink;
   assign unused_blink = blink ^ (BLINK_DIV == 0);
   assign hide         = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         hex_out  <= '1;
         overflow <= 1'b0;
      end else begin
         hex_out  <= hide ? '1 : disp;
         overflow <= ovf_r;
      end
   end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (default build, 6 digits, 24-bit value).
module tb_seg7_display_ctrl;

   localparam int ND = 6;
   localparam int VW = 24;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S9 = 7'b0010000, SA = 7'b0001000,
                          SB = 7'b0000011, SC = 7'b1000110, BL = 7'b1111111,
                          DS = 7'b0111111;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b1;
   logic [VW-1:0]     value = '0;
   logic              load = 1'b0, mode_dec = 1'b0, blank_lz = 1'b0, blink = 1'b0;
   logic [7*ND-1:0]   hex_out;
   logic              busy, overflow;
   logic [7*ND-1:0]   first;

   int checks = 0;
   int failures = 0;
   int changes;

   seg7_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .BLINK_DIV(4)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .value(value), .load(load),
      .mode_dec(mode_dec), .blank_lz(blank_lz), .blink(blink),
      .hex_out(hex_out), .busy(busy), .overflow(overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // leaves the bench 1 time unit after the accepting edge N
   task automatic do_load(input logic [VW-1:0] v, input logic dec, input logic blz);
      @(negedge CLOCK_50);
      value = v; mode_dec = dec; blank_lz = blz; load = 1'b1;
      @(posedge CLOCK_50); #1;
      load = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      step(3);
      chk("rst_hex", hex_out, {ND{BL}});
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      @(negedge CLOCK_50); reset = 1'b0;

      // hex mode: valid two edges after load, busy never set
      do_load(24'hABC123, 1'b0, 1'b0);
      step(1);
      chk("hex_busy1", busy, 1'b0);
      chk("hex_hold", hex_out, {ND{BL}});
      step(1);
      chk("hex_val", hex_out, {SA, SB, SC, S1, S2, S3});
      chk("hex_hex0", hex_out[6:0], S3);
      chk("hex_busy2", busy, 1'b0);
      chk("hex_ovf", overflow, 1'b0);

      // reset in the middle of a decimal conversion
      do_load(24'd999999, 1'b1, 1'b0);
      step(9);
      @(negedge CLOCK_50); reset = 1'b1; #1;
      chk("rstc_hex", hex_out, {ND{BL}});
      chk("rstc_busy", busy, 1'b0);
      chk("rstc_ovf", overflow, 1'b0);
      @(negedge CLOCK_50); reset = 1'b0;
      step(30);
      chk("rstc_noupd", hex_out, {ND{BL}});

      // decimal latency and busy window
      do_load(24'd123456, 1'b1, 1'b0);
      chk("dec_busyN", busy, 1'b0);
      step(1);
      chk("dec_busyN1", busy, 1'b1);
      step(VW);
      chk("dec_busyNW1", busy, 1'b1);
      chk("dec_hold", hex_out, {ND{BL}});
      step(1);
      chk("dec_busy_end", busy, 1'b0);
      chk("dec_val", hex_out, {S1, S2, S3, S4, S5, S6});
      chk("dec_ovf", overflow, 1'b0);

      do_load(24'd1000000, 1'b1, 1'b0);
      step(VW + 2);
      chk("ovf_dash", hex_out, {ND{DS}});
      chk("ovf_flag", overflow, 1'b1);

      do_load(24'd0, 1'b1, 1'b1);
      step(VW + 2);
      chk("zero_blank", hex_out, {BL, BL, BL, BL, BL, S0});
      chk("zero_ovf", overflow, 1'b0);

      // second load during busy is dropped, not queued
      do_load(24'd42, 1'b1, 1'b0);
      step(4);
      @(negedge CLOCK_50); value = 24'd7; load = 1'b1;
      @(posedge CLOCK_50); #1; load = 1'b0;
      step(VW + 2 - 5);
      chk("ign_val", hex_out, {S0, S0, S0, S0, S4, S2});
      chk("ign_busy", busy, 1'b0);
      step(30);
      chk("ign_noq", hex_out, {S0, S0, S0, S0, S4, S2});

      do_load(24'd999999, 1'b1, 1'b0);
      step(VW + 2);
      chk("max_val", hex_out, {ND{S9}});
      chk("max_ovf", overflow, 1'b0);

      do_load(24'h000A05, 1'b0, 1'b1);
      step(2);
      chk("hex_blank", hex_out, {BL, BL, BL, SA, S0, S5});

      // load during the SHOW cycle is ignored
      do_load(24'h111111, 1'b0, 1'b0);
      @(negedge CLOCK_50); value = 24'h222222; load = 1'b1;
      @(posedge CLOCK_50); #1; load = 1'b0;
      step(1);
      chk("show_val", hex_out, {ND{S1}});
      step(3);
      chk("show_ign", hex_out, {ND{S1}});

      // blink has no effect without the optional feature
      blink = 1'b1;
      first = hex_out;
      changes = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (hex_out !== first) changes++;
      end
      chk("blink_const", 64'(changes), 64'd0);
      chk("blink_val", hex_out, {ND{S1}});
      blink = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
